dmem_arbiter: RTL and testbench

//  Shares the CPU's single-port synchronous data RAM between the CPU load/store path (port C)
//  and a host/debug port (port H) used for loading and inspecting data memory.

---
 rtl/dmem_arb_pkg.sv | 17 +
 rtl/dmem_arb_rr2.sv | 43 ++++
 rtl/dmem_arbiter.sv | 140 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
//   Shared types for the data-memory arbiter: host lock state and the encoding
//   used to name the owning port of an access (CPU or host).
//   No ports (package).
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } lock_state_e;

   localparam logic OWN_C = 1'b0;
   localparam logic OWN_H = 1'b1;

endpackage

// File: rtl/dmem_arb_rr2.sv
// -----------------------------------------------------------------------------
// dmem_arb_rr2
//   Two-way round-robin picker between the CPU (C) and host (H) requesters.
//   Ports:
//     req_c, req_h   in   requests from CPU / host
//     rr_last        in   owner of the most recent grant (OWN_C / OWN_H)
//     force_c        in   grant C regardless of mask or tie state
//     mask_c         in   C not eligible for normal arbitration
//     gnt_c, gnt_h   out  one-hot (or zero) grant
// -----------------------------------------------------------------------------
module dmem_arb_rr2
   import dmem_arb_pkg::*;
(
   input  logic req_c,
   input  logic req_h,
   input  logic rr_last,
   input  logic force_c,
   input  logic mask_c,
   output logic gnt_c,
   output logic gnt_h
);

   logic elig_c;

   always_comb begin
      gnt_c  = 1'b0;
      gnt_h  = 1'b0;
      elig_c = req_c & ~mask_c;
      if (force_c && req_c) begin
         // Anti-starvation slot overrides the host lock mask.
         gnt_c = 1'b1;
      end else if (elig_c && req_h) begin
         // Tie: whoever did not win last time gets it.
         if (rr_last == OWN_H) gnt_c = 1'b1;
         else                  gnt_h = 1'b1;
      end else if (elig_c) begin
         gnt_c = 1'b1;
      end else if (req_h) begin
         gnt_h = 1'b1;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares a single-port synchronous data RAM between the CPU load/store path
//   (port C) and a host/debug port (port H). One access is granted per cycle;
//   read data returns one cycle after the grant to the owning port only. The
//   host can lock the RAM for back-to-back bursts, bounded by MAX_LOCK cycles
//   of CPU starvation after which the CPU gets one forced slot.
//   Ports:
//     CLOCK_50, reset                  clock, synchronous active-high reset
//     c_req/c_we/c_addr/c_wdata        CPU request (held until c_gnt)
//     h_req/h_we/h_addr/h_wdata        host request (held until h_gnt)
//     h_lock                           host asks for exclusive ownership
//     c_gnt/h_gnt                      access accepted this cycle
//     c_rvalid/c_rdata, h_rvalid/h_rdata  read return, zero when not valid
//     cpu_stall                        CPU must hold its pipeline
//     ram_read_enable/ram_write_enable/ram_address/ram_write_data  to RAM
//     ram_read_data                    from RAM, one cycle after read strobe
// -----------------------------------------------------------------------------
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 32,
   parameter int MAX_LOCK = 16
)(
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   input  logic              h_req,
   input  logic              h_we,
   input  logic [ADDR_W-1:0] h_addr,
   input  logic [DATA_W-1:0] h_wdata,
   input  logic              h_lock,
   output logic              c_gnt,
   output logic              h_gnt,
   output logic              c_rvalid,
   output logic [DATA_W-1:0] c_rdata,
   output logic              h_rvalid,
   output logic [DATA_W-1:0] h_rdata,
   output logic              cpu_stall,
   output logic              ram_read_enable,
   output logic              ram_write_enable,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_write_data,
   input  logic [DATA_W-1:0] ram_read_data
);

   localparam int               CNT_W   = $clog2(MAX_LOCK + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

   lock_state_e      state_q, state_d;
   logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
   logic             rr_last_q, rr_last_d;
   logic             rd_pend_q, rd_pend_d;
   logic             rd_owner_q, rd_owner_d;

   logic             req_c_ok, req_h_ok;
   logic             force_c, mask_c;

   // No grants while reset is asserted, so nothing can be issued in that cycle.
   assign req_c_ok = c_req & ~reset;
   assign req_h_ok = h_req & ~reset;
   assign mask_c   = (state_q == LOCKED);
   assign force_c  = (state_q == LOCKED) && (lock_cnt_q == CNT_MAX);

   dmem_arb_rr2 u_rr (
      .req_c   (req_c_ok),
      .req_h   (req_h_ok),
      .rr_last (rr_last_q),
      .force_c (force_c),
      .mask_c  (mask_c),
      .gnt_c   (c_gnt),
      .gnt_h   (h_gnt)
   );

   // ---- state register ------------------------------------------------------
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q    <= UNLOCKED;
         lock_cnt_q <= '0;
         rr_last_q  <= OWN_H;
         rd_pend_q  <= 1'b0;
         rd_owner_q <= OWN_C;
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
         rr_last_q  <= rr_last_d;
         rd_pend_q  <= rd_pend_d;
         rd_owner_q <= rd_owner_d;
      end
   end

   // ---- next-state logic ----------------------------------------------------
   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      rr_last_d  = rr_last_q;
      if (c_gnt)      rr_last_d = OWN_C;
      else if (h_gnt) rr_last_d = OWN_H;

      rd_pend_d  = (c_gnt & ~c_we) | (h_gnt & ~h_we);
      rd_owner_d = h_gnt ? OWN_H : OWN_C;

      if (state_q == UNLOCKED) begin
         lock_cnt_d = '0;
         // Lock is only taken on an actual host grant.
         if (h_gnt && h_lock) state_d = LOCKED;
      end else begin
         if (!h_lock) begin
            state_d    = UNLOCKED;
            lock_cnt_d = '0;
         end else if (c_gnt) begin
            lock_cnt_d = '0;
         end else if (c_req && (lock_cnt_q != CNT_MAX)) begin
            lock_cnt_d = lock_cnt_q + 1'b1;
         end
      end
   end

   // ---- outputs -------------------------------------------------------------
   always_comb begin
      ram_address      = h_gnt ? h_addr  : c_addr;
      ram_write_data   = h_gnt ? h_wdata : c_wdata;
      ram_read_enable  = (c_gnt & ~c_we) | (h_gnt & ~h_we);
      ram_write_enable = (c_gnt &  c_we) | (h_gnt &  h_we);

      // A read pending across a reset edge is dropped, never returned.
      c_rvalid = ~reset & rd_pend_q & (rd_owner_q == OWN_C);
      h_rvalid = ~reset & rd_pend_q & (rd_owner_q == OWN_H);
      c_rdata  = c_rvalid ? ram_read_data : '0;
      h_rdata  = h_rvalid ? ram_read_data : '0;

      // Writes finish on the grant, reads on the data return.
      cpu_stall = c_req & ~(c_we ? c_gnt : c_rvalid);
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

   localparam int ADDR_W   = 8;
   localparam int DATA_W   = 32;
   localparam int MAX_LOCK = 16;

   logic              CLOCK_50 = 1'b0;
   logic              reset;
   logic              c_req, c_we, h_req, h_we, h_lock;
   logic [ADDR_W-1:0] c_addr, h_addr;
   logic [DATA_W-1:0] c_wdata, h_wdata;
   logic              c_gnt, h_gnt, c_rvalid, h_rvalid, cpu_stall;
   logic [DATA_W-1:0] c_rdata, h_rdata;
   logic              ram_read_enable, ram_write_enable;
   logic [ADDR_W-1:0] ram_address;
   logic [DATA_W-1:0] ram_write_data, ram_read_data;

   dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(MAX_LOCK)) dut (
      .CLOCK_50         (CLOCK_50),
      .reset            (reset),
      .c_req            (c_req),
      .c_we             (c_we),
      .c_addr           (c_addr),
      .c_wdata          (c_wdata),
      .h_req            (h_req),
      .h_we             (h_we),
      .h_addr           (h_addr),
      .h_wdata          (h_wdata),
      .h_lock           (h_lock),
      .c_gnt            (c_gnt),
      .h_gnt            (h_gnt),
      .c_rvalid         (c_rvalid),
      .c_rdata          (c_rdata),
      .h_rvalid         (h_rvalid),
      .h_rdata          (h_rdata),
      .cpu_stall        (cpu_stall),
      .ram_read_enable  (ram_read_enable),
      .ram_write_enable (ram_write_enable),
      .ram_address      (ram_address),
      .ram_write_data   (ram_write_data),
      .ram_read_data    (ram_read_data)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // Single-port synchronous RAM, one-cycle read latency.
   logic [DATA_W-1:0] mem [0:255];
   logic [DATA_W-1:0] rd_q;
   always @(posedge CLOCK_50) begin
      if (ram_write_enable) mem[ram_address] <= ram_write_data;
      if (ram_read_enable)  rd_q <= mem[ram_address];
   end
   assign ram_read_data = rd_q;

   int cyc = 0;
   always @(posedge CLOCK_50) cyc <= cyc + 1;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
   endtask

   // Scoreboard: expected read returns per port, with the cycle they are due.
   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;
   exp_t c_q[$];
   exp_t h_q[$];
   exp_t mon_e;

   always @(negedge CLOCK_50) begin
      if (!reset) begin
         if (c_rvalid) begin
            if (c_q.size() == 0) check1("c_rvalid_unexpected", 1'b1, 1'b0);
            else begin
               mon_e = c_q.pop_front();
               check32("c_rdata", c_rdata, mon_e.data);
               check32("c_rvalid_cycle", cyc, mon_e.due);
               check32("c_ret_h_rdata_zero", h_rdata, 32'h0);
            end
         end
         if (h_rvalid) begin
            if (h_q.size() == 0) check1("h_rvalid_unexpected", 1'b1, 1'b0);
            else begin
               mon_e = h_q.pop_front();
               check32("h_rdata", h_rdata, mon_e.data);
               check32("h_rvalid_cycle", cyc, mon_e.due);
               check32("h_ret_c_rdata_zero", c_rdata, 32'h0);
            end
         end
      end
   end

   task automatic next_cycle();
      @(posedge CLOCK_50);
      #1;
      c_req = 1'b0; c_we = 1'b0;
      h_req = 1'b0; h_we = 1'b0; h_lock = 1'b0;
   endtask

   task automatic sample();
      @(negedge CLOCK_50);
   endtask

   task automatic host_write(input logic [7:0] a, input logic [31:0] d);
      next_cycle();
      h_req = 1'b1; h_we = 1'b1; h_addr = a; h_wdata = d;
      sample();
      check1("preload_h_gnt", h_gnt, 1'b1);
   endtask

   task automatic pulse_reset();
      next_cycle();
      reset = 1'b1;
      sample();
      next_cycle();
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   logic [7:0] ci, hi;
   int         starve;
   logic       c_done, chk_resume, resumed;

   initial begin
      reset = 1'b1;
      c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
      h_req = 0; h_we = 0; h_addr = '0; h_wdata = '0; h_lock = 0;

      // ---- reset values, CPU requesting a read during reset ----
      next_cycle();
      c_req = 1'b1; c_addr = 8'h10;
      sample();
      check1("rst_c_gnt", c_gnt, 1'b0);
      check1("rst_h_gnt", h_gnt, 1'b0);
      check1("rst_ram_re", ram_read_enable, 1'b0);
      check1("rst_ram_we", ram_write_enable, 1'b0);
      check1("rst_cpu_stall", cpu_stall, 1'b1);
      check1("rst_c_rvalid", c_rvalid, 1'b0);
      check32("rst_c_rdata", c_rdata, 32'h0);
      check32("rst_h_rdata", h_rdata, 32'h0);
      next_cycle();
      reset = 1'b0;

      // ---- CPU-only read ----
      host_write(8'h10, 32'hDEADBEEF);
      next_cycle();
      c_req = 1'b1; c_we = 1'b0; c_addr = 8'h10;
      sample();
      check1("cpu_rd_c_gnt", c_gnt, 1'b1);
      check1("cpu_rd_stall_gnt", cpu_stall, 1'b1);
      check1("cpu_rd_ram_re", ram_read_enable, 1'b1);
      check32("cpu_rd_ram_addr", 32'(ram_address), 32'h10);
      c_q.push_back('{32'hDEADBEEF, cyc + 1});
      next_cycle();
      sample();
      check1("cpu_rd_c_rvalid", c_rvalid, 1'b1);
      check1("cpu_rd_stall_ret", cpu_stall, 1'b0);
      check1("cpu_rd_h_rvalid", h_rvalid, 1'b0);

      // ---- tie from reset: alternate C,H,C,H ----
      pulse_reset();
      ci = 0; hi = 0;
      for (int k = 0; k < 8; k++) begin
         if (k != 0) next_cycle();
         c_req = 1'b1; c_we = 1'b1; c_addr = 8'h20 + ci; c_wdata = 32'hC000_0000 + 32'(ci);
         h_req = 1'b1; h_we = 1'b1; h_addr = 8'h40 + hi; h_wdata = 32'hA000_0000 + 32'(hi);
         sample();
         check1("tie_c_gnt", c_gnt, (k % 2) == 0);
         check1("tie_h_gnt", h_gnt, (k % 2) == 1);
         if (c_gnt) ci++;
         if (h_gnt) hi++;
      end
      next_cycle();
      sample();
      for (int i = 0; i < 4; i++) begin
         check32("tie_mem_c", mem[8'h20 + 8'(i)], 32'hC000_0000 + 32'(i));
         check32("tie_mem_h", mem[8'h40 + 8'(i)], 32'hA000_0000 + 32'(i));
      end

      // ---- host lock burst, CPU starved MAX_LOCK cycles then one forced slot ----
      pulse_reset();
      h_req = 1'b1; h_we = 1'b1; h_lock = 1'b1; h_addr = 8'h00; h_wdata = 32'h0;
      sample();
      check1("lock_first_h_gnt", h_gnt, 1'b1);
      hi = 8'd1; starve = 0; c_done = 1'b0; chk_resume = 1'b0; resumed = 1'b0;
      for (int k = 0; k < 80 && hi < 8'd32; k++) begin
         next_cycle();
         h_req = 1'b1; h_we = 1'b1; h_lock = 1'b1; h_addr = hi; h_wdata = 32'(hi);
         if (!c_done) begin
            c_req = 1'b1; c_we = 1'b1; c_addr = 8'h80; c_wdata = 32'h55;
         end
         sample();
         if (chk_resume) begin
            resumed = h_gnt;
            chk_resume = 1'b0;
         end
         if (c_req && !c_gnt) starve++;
         if (c_gnt) begin
            c_done = 1'b1;
            chk_resume = 1'b1;
         end
         if (h_gnt) hi++;
      end
      check32("lock_starve_cycles", 32'(starve), 32'd16);
      check1("lock_c_forced_gnt", c_done, 1'b1);
      check1("lock_host_resumes", resumed, 1'b1);
      check32("lock_host_all_written", 32'(hi), 32'd32);
      next_cycle();               // release lock, idle
      sample();
      next_cycle();
      c_req = 1'b1; c_we = 1'b1; c_addr = 8'h81; c_wdata = 32'h66;
      h_req = 1'b1; h_we = 1'b1; h_addr = 8'h90; h_wdata = 32'h77;
      sample();
      check1("unlock_rr_c_first", c_gnt, 1'b1);
      next_cycle();
      c_req = 1'b1; c_we = 1'b1; c_addr = 8'h82; c_wdata = 32'h88;
      h_req = 1'b1; h_we = 1'b1; h_addr = 8'h90; h_wdata = 32'h77;
      sample();
      check1("unlock_rr_h_second", h_gnt, 1'b1);
      next_cycle();
      sample();
      check32("lock_mem_00", mem[8'h00], 32'h0);
      check32("lock_mem_1f", mem[8'h1F], 32'h1F);
      check32("lock_mem_80", mem[8'h80], 32'h55);
      check32("unlock_mem_90", mem[8'h90], 32'h77);

      // ---- read routing: H read then C read back-to-back ----
      host_write(8'h30, 32'h1111_2222);
      host_write(8'h31, 32'h3333_4444);
      next_cycle();
      h_req = 1'b1; h_we = 1'b0; h_addr = 8'h30;
      sample();
      check1("route_h_gnt", h_gnt, 1'b1);
      h_q.push_back('{32'h1111_2222, cyc + 1});
      next_cycle();
      c_req = 1'b1; c_we = 1'b0; c_addr = 8'h31;
      sample();
      check1("route_c_gnt_on_return", c_gnt, 1'b1);
      check1("route_n1_h_rvalid", h_rvalid, 1'b1);
      check1("route_n1_c_rvalid", c_rvalid, 1'b0);
      check32("route_n1_c_rdata", c_rdata, 32'h0);
      c_q.push_back('{32'h3333_4444, cyc + 1});
      next_cycle();
      sample();
      check1("route_n2_c_rvalid", c_rvalid, 1'b1);
      check1("route_n2_h_rvalid", h_rvalid, 1'b0);
      check32("route_n2_h_rdata", h_rdata, 32'h0);

      // ---- reset while a read is in flight ----
      next_cycle();
      c_req = 1'b1; c_we = 1'b0; c_addr = 8'h10;
      sample();
      check1("rstrd_c_gnt", c_gnt, 1'b1);
      next_cycle();
      reset = 1'b1;
      c_req = 1'b1; c_we = 1'b0; c_addr = 8'h10;
      sample();
      check1("rstrd_c_rvalid", c_rvalid, 1'b0);
      check32("rstrd_c_rdata", c_rdata, 32'h0);
      check1("rstrd_c_gnt_in_rst", c_gnt, 1'b0);
      check1("rstrd_ram_re", ram_read_enable, 1'b0);
      check1("rstrd_cpu_stall", cpu_stall, 1'b1);
      next_cycle();
      reset = 1'b0;
      sample();
      check1("rstrd_no_late_c_rvalid", c_rvalid, 1'b0);
      check1("rstrd_no_late_h_rvalid", h_rvalid, 1'b0);

      // ---- CPU write then read same address ----
      next_cycle();
      c_req = 1'b1; c_we = 1'b1; c_addr = 8'h05; c_wdata = 32'h1234_5678;
      sample();
      check1("wr_c_gnt", c_gnt, 1'b1);
      check1("wr_no_stall", cpu_stall, 1'b0);
      next_cycle();
      c_req = 1'b1; c_we = 1'b0; c_addr = 8'h05;
      sample();
      check1("rd5_c_gnt", c_gnt, 1'b1);
      check1("rd5_stall", cpu_stall, 1'b1);
      c_q.push_back('{32'h1234_5678, cyc + 1});
      next_cycle();
      sample();
      check1("rd5_c_rvalid", c_rvalid, 1'b1);

      next_cycle();
      sample();
      check32("sb_c_drained", 32'(c_q.size()), 32'd0);
      check32("sb_h_drained", 32'(h_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
